// File: rtl/edge_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_arb_pkg
// Description : Shared types, constants and the round-robin pick helper for
//               the edge event arbiter.
//               Contents: evt_slot_t (pending slot), rr_pick_t (pick result),
//               FILL_CYCLES (edge suppression after reset release),
//               rr_pick() (rotating first-set search).
// Revision    : 1.0 - initial release
// ============================================================================
package edge_arb_pkg;

    // History registers need this many clocks after reset release before
    // their contents reflect real input levels.
    localparam int FILL_CYCLES = 2;

    // Upper bounds used to size package-level types independently of the
    // per-instance parameters; instances use the low bits only.
    localparam int c_MAX_CH    = 16;
    localparam int c_MAX_IDX_W = 4;
    localparam int c_TS_W_MAX  = 32;

    typedef struct packed {
        logic                  pend;
        logic                  rise;
        logic [c_TS_W_MAX-1:0] ts;
    } evt_slot_t;

    typedef struct packed {
        logic                   found;
        logic [c_MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Search req starting at ptr+1, wrapping at num-1 -> 0. The previous
    // winner (ptr) is examined last, which gives round-robin fairness.
    function automatic rr_pick_t rr_pick(
        input logic [c_MAX_CH-1:0]    req,
        input logic [c_MAX_IDX_W-1:0] ptr,
        input int                     num
    );
        rr_pick_t r_res;
        int       j;
        r_res = '0;
        for (int k = 1; k <= c_MAX_CH; k++) begin
            if (k <= num) begin
                j = (int'(ptr) + k) % num;
                if (!r_res.found && req[j]) begin
                    r_res.found = 1'b1;
                    r_res.idx   = c_MAX_IDX_W'(j);
                end
            end
        end
        return r_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_event_arbiter_edge_sense.sv
`default_nettype none
// ============================================================================
// Module      : edge_sense
// Description : Per-channel two-stage level history, fill gate and
//               registered rise/fall pulse generation.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   i_d    in   synchronous level input
//   o_rise out  one-clock pulse, registered, for a 0->1 level change
//   o_fall out  one-clock pulse, registered, for a 1->0 level change
// Revision    : 1.0 - initial release
// ============================================================================
module edge_sense
    import edge_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_FILL_W = $clog2(FILL_CYCLES + 1);

    logic                r_d_q;
    logic                r_d_qq;
    logic                r_rise;
    logic                r_fall;
    logic [c_FILL_W-1:0] r_fill;
    logic                w_armed;

    // Until the history has been refilled from real input samples, the
    // reset-zero contents would fake a rising edge on any level that was
    // already high at reset release.
    assign w_armed = (r_fill == c_FILL_W'(FILL_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_q  <= 1'b0;
            r_d_qq <= 1'b0;
            r_fill <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_d_q  <= i_d;
            r_d_qq <= r_d_q;
            if (!w_armed) begin
                r_fill <= r_fill + c_FILL_W'(1);
            end
            r_rise <= w_armed &  r_d_q & ~r_d_qq;
            r_fall <= w_armed & ~r_d_q &  r_d_qq;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter
// Description : Captures rise/fall edges on NUM_CH level inputs, holds one
//               pending event per channel and serialises them round-robin
//               onto a single valid/ready stream. Counts dropped edges.
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   d          in   [NUM_CH] level inputs
//   ch_en      in   [NUM_CH] per-channel capture enable
//   evt_valid  out  event available
//   evt_ready  in   consumer accept
//   evt_ch     out  channel index of the presented event
//   evt_rise   out  1 = rising, 0 = falling
//   evt_ts     out  capture timestamp (zero unless timestamps enabled)
//   drop_cnt   out  saturating dropped-edge count
//   drop_clr   in   synchronous clear of drop_cnt (wins over increment)
// Build option: define EDGE_ARB_TIMESTAMP_EN to add a free-running capture
//               timestamp carried with each event.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int TS_W   = 16
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         d,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic                      evt_rise,
    output logic [TS_W-1:0]           evt_ts,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      drop_clr
);

    localparam int c_IDX_W = $clog2(NUM_CH);
    localparam int c_DN_W  = $clog2(NUM_CH + 1);
    localparam int c_SUM_W = CNT_W + c_DN_W;

    logic [NUM_CH-1:0]     w_rise;
    logic [NUM_CH-1:0]     w_fall;
    logic [NUM_CH-1:0]     w_edge;
    evt_slot_t             r_slot [NUM_CH];
    logic [NUM_CH-1:0]     w_req;
    logic [NUM_CH-1:0]     w_free;
    logic [NUM_CH-1:0]     w_cap;
    logic [NUM_CH-1:0]     w_drop;
    logic [c_DN_W-1:0]     w_drop_n;
    logic [c_SUM_W-1:0]    w_drop_sum;
    logic [CNT_W-1:0]      w_drop_nxt;
    logic [CNT_W-1:0]      r_drop_cnt;
    rr_pick_t              w_pick;
    logic                  w_load;
    logic                  w_grant;
    logic [c_IDX_W-1:0]    w_gidx;
    logic [c_IDX_W-1:0]    r_ptr;
    logic                  r_valid;
    logic [c_IDX_W-1:0]    r_ch;
    logic                  r_rise;
    logic [c_TS_W_MAX-1:0] w_ts_now;
    logic                  w_unused;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_sense
            edge_sense u_sense (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_d    (d[g]),
                .o_rise (w_rise[g]),
                .o_fall (w_fall[g])
            );
        end
    endgenerate

    assign w_edge = w_rise | w_fall;

    // ---------------------------------------------------------------- arbiter
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_req[i] = r_slot[i].pend;
        end
    end

    assign w_pick  = rr_pick(c_MAX_CH'(w_req), c_MAX_IDX_W'(r_ptr), NUM_CH);
    assign w_load  = ~r_valid | evt_ready;
    assign w_grant = w_load & w_pick.found;
    assign w_gidx  = w_pick.idx[c_IDX_W-1:0];

    // A slot being handed to the output register this cycle may take a new
    // edge in the same cycle, so a freed slot counts as empty.
    always_comb begin
        w_free = '0;
        w_cap  = '0;
        w_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_free[i] = w_grant && (w_gidx == c_IDX_W'(i));
            w_cap[i]  = ch_en[i] && w_edge[i] && (!r_slot[i].pend || w_free[i]);
            w_drop[i] = ch_en[i] && w_edge[i] && r_slot[i].pend && !w_free[i];
        end
    end

    // ------------------------------------------------------------- timestamp
`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_evt_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
            r_evt_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + TS_W'(1);
            if (w_grant) begin
                r_evt_ts <= r_slot[w_gidx].ts[TS_W-1:0];
            end
        end
    end

    assign w_ts_now = c_TS_W_MAX'(r_ts_cnt);
    assign evt_ts   = r_evt_ts;
`else
    assign w_ts_now = '0;
    assign evt_ts   = '0;
`endif

    // ----------------------------------------------------------------- slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cap[i]) begin
                    r_slot[i].pend <= 1'b1;
                    r_slot[i].rise <= w_rise[i];
                    r_slot[i].ts   <= w_ts_now;
                end else if (w_free[i]) begin
                    r_slot[i].pend <= 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------- drop counter
    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_n = w_drop_n + c_DN_W'(w_drop[i]);
        end
    end

    // Sum in a wider word so a carry past the counter width means saturate.
    assign w_drop_sum = c_SUM_W'(r_drop_cnt) + c_SUM_W'(w_drop_n);
    assign w_drop_nxt = (|w_drop_sum[c_SUM_W-1:CNT_W]) ? '1 : w_drop_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (drop_clr) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
        end
    end

    // ------------------------------------------------------- output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_rise  <= 1'b0;
            r_ptr   <= c_IDX_W'(NUM_CH - 1);
        end else if (w_load) begin
            r_valid <= w_pick.found;
            if (w_pick.found) begin
                r_ch   <= w_gidx;
                r_rise <= r_slot[w_gidx].rise;
                r_ptr  <= w_gidx;
            end
        end
    end

    assign evt_valid = r_valid;
    assign evt_ch    = r_ch;
    assign evt_rise  = r_rise;
    assign drop_cnt  = r_drop_cnt;

    // Package types are sized for the largest configuration; the bits above
    // this instance's widths are intentionally left unread.
    always_comb begin
        w_unused = ^w_pick.idx;
        for (int i = 0; i < NUM_CH; i++) begin
            w_unused = w_unused ^ (^r_slot[i].ts);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_event_arbiter
// Description : Directed self-checking bench for edge_event_arbiter
//               (NUM_CH=4, CNT_W=8, TS_W=16). Honours EDGE_ARB_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  d         = 4'h0;
    logic [3:0]  ch_en     = 4'hF;
    logic        evt_ready = 1'b0;
    logic        drop_clr  = 1'b0;
    logic        evt_valid;
    logic [1:0]  evt_ch;
    logic        evt_rise;
    logic [15:0] evt_ts;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    edge_event_arbiter #(
        .NUM_CH (4),
        .CNT_W  (8),
        .TS_W   (16)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .ch_en     (ch_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_ts    (evt_ts),
        .drop_cnt  (drop_cnt),
        .drop_clr  (drop_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] dv);
        rst_n     = 1'b0;
        d         = dv;
        ch_en     = 4'hF;
        evt_ready = 1'b0;
        drop_clr  = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    logic        seen;
    int          n_evt;
    logic [15:0] ts_a;
    logic [15:0] ts_b;

    initial begin
        // ---- 1: reset values; levels high at release make no event
        step(1);
        do_reset(4'hF);
        rst_n = 1'b0;
        step(1);
        chk("rst_valid", evt_valid, 0);
        chk("rst_ch",    evt_ch,    0);
        chk("rst_rise",  evt_rise,  0);
        chk("rst_ts",    evt_ts,    0);
        chk("rst_drop",  drop_cnt,  0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        seen      = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            seen = seen | evt_valid;
        end
        chk("t1_no_event", seen, 0);
        chk("t1_drop", drop_cnt, 0);

        // ---- 2: single rise on ch2, valid three clocks after sampling edge
        do_reset(4'h0);
        evt_ready = 1'b1;
        step(3);
        d[2] = 1'b1;
        step(3);
        chk("t2_not_early", evt_valid, 0);
        step(1);
        chk("t2_valid", evt_valid, 1);
        chk("t2_ch",    evt_ch,    2);
        chk("t2_rise",  evt_rise,  1);
        step(1);
        chk("t2_one_cycle", evt_valid, 0);
        d[2] = 1'b0;
        step(4);
        chk("t2_fall_valid", evt_valid, 1);
        chk("t2_fall_ch",    evt_ch,    2);
        chk("t2_fall_rise",  evt_rise,  0);

        // ---- 3: all channels at once, round-robin order twice
        do_reset(4'h0);
        evt_ready = 1'b1;
        step(3);
        d = 4'hF;
        step(4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_rise_valid", evt_valid, 1);
            chk("t3_rise_ch",    evt_ch,    i);
            chk("t3_rise_dir",   evt_rise,  1);
            step(1);
        end
        chk("t3_rise_done", evt_valid, 0);
        d = 4'h0;
        step(4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_fall_valid", evt_valid, 1);
            chk("t3_fall_ch",    evt_ch,    i);
            chk("t3_fall_dir",   evt_rise,  0);
            step(1);
        end
        chk("t3_fall_done", evt_valid, 0);

        // ---- 4: back-pressure overflow on ch1. Output register holds the
        // first rise, the slot holds the next fall, the remaining two drop.
        do_reset(4'h0);
        step(3);
        d[1] = 1'b1; step(1);
        d[1] = 1'b0; step(1);
        d[1] = 1'b1; step(1);
        d[1] = 1'b0;
        step(6);
        chk("t4_held_valid", evt_valid, 1);
        chk("t4_held_ch",    evt_ch,    1);
        chk("t4_held_rise",  evt_rise,  1);
        chk("t4_drop",       drop_cnt,  2);
        evt_ready = 1'b1;
        step(1);
        chk("t4_next_valid", evt_valid, 1);
        chk("t4_next_rise",  evt_rise,  0);
        step(1);
        chk("t4_empty", evt_valid, 0);
        drop_clr = 1'b1;
        step(1);
        drop_clr = 1'b0;
        chk("t4_clr", drop_cnt, 0);

        // ---- 4b: multi-channel drops add, counter saturates, clear wins
        do_reset(4'h0);
        step(3);
        d = 4'hF; step(1);
        d = 4'h0; step(1);
        d = 4'hF;
        step(4);
        chk("t4_multi_drop", drop_cnt, 7);
        for (int c = 0; c < 70; c++) begin
            d = ~d;
            step(1);
        end
        chk("t4_saturate", drop_cnt, 8'hFF);
        d        = ~d;
        drop_clr = 1'b1;
        step(1);
        chk("t4_clr_wins", drop_cnt, 0);
        drop_clr = 1'b0;

        // ---- 5: disabled channel ignored; timestamps
        do_reset(4'h0);
        ch_en     = 4'b1110;
        evt_ready = 1'b1;
        step(3);
        d[0] = 1'b1; step(1);
        d[0] = 1'b0; step(1);
        d[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            seen = seen | evt_valid;
        end
        chk("t5_ch0_masked", seen, 0);
        n_evt = 0;
        ts_a  = '0;
        ts_b  = '0;
        d[3]  = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step(1);
            if (evt_valid) begin
                if (n_evt == 0) ts_a = evt_ts;
                else            ts_b = evt_ts;
                n_evt++;
            end
            if (c == 5) d[3] = 1'b0;
        end
        chk("t5_evt_count", n_evt, 2);
`ifdef EDGE_ARB_TIMESTAMP_EN
        chk("t5_ts_diff", 32'(ts_b - ts_a), 5);
`else
        chk("t5_ts_a_zero", ts_a, 0);
        chk("t5_ts_b_zero", ts_b, 0);
`endif

        // ---- 6: asynchronous reset with an event presented and 3 pending
        do_reset(4'h0);
        step(3);
        d = 4'hF;
        step(4);
        chk("t6_pre_valid", evt_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", evt_valid, 0);
        chk("t6_async_ch",    evt_ch,    0);
        step(2);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        seen      = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            seen = seen | evt_valid;
        end
        chk("t6_no_stale", seen, 0);
        chk("t6_drop",     drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
